// File: rtl/core_run_ctrl.sv
// core_run_ctrl
// Run controller for one or more RISC-V cores. Holds the core(s) in reset for
// RESET_CYCLES cycles after a start pulse, releases them, counts run cycles and
// watches each hart's data-memory write port for a store to TOHOST_ADDR. The
// run ends on full completion (every hart stored) or on the MAX_CYCLES budget.
//
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   start        launch / relaunch pulse (honoured in IDLE and DONE)
//   mem_we       per-hart store enable
//   mem_addr     per-hart store address, hart i at [i*ADDR_W +: ADDR_W]
//   mem_wdata    per-hart store data, hart i at [i*DATA_W +: DATA_W]
//   core_rst     reset to the core(s), high everywhere except RUN
//   running      high in RUN
//   done         high in DONE
//   pass         every hart stored 1 and no timeout (valid when done)
//   timeout      run budget exhausted before completion (valid when done)
//   hart_done    per-hart completion store seen
//   exit_code    failing value of the lowest-index failing hart, else 0
//   cycle_count  run cycles elapsed
module core_run_ctrl #(
    parameter int                NUM_HARTS    = 1,
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                CNT_W        = 32,
    parameter int                RESET_CYCLES = 1,
    parameter int                MAX_CYCLES   = 25,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 32'h0000_1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_HARTS-1:0]        mem_we,
    input  logic [NUM_HARTS*ADDR_W-1:0] mem_addr,
    input  logic [NUM_HARTS*DATA_W-1:0] mem_wdata,
    output logic                        core_rst,
    output logic                        running,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout,
    output logic [NUM_HARTS-1:0]        hart_done,
    output logic [DATA_W-1:0]           exit_code,
    output logic [CNT_W-1:0]            cycle_count
);

    localparam int IDX_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       rst_cnt;
    logic                   any_fail;
    logic [IDX_W-1:0]       fail_idx;

    logic [NUM_HARTS-1:0]   new_done;
    logic [NUM_HARTS-1:0]   new_fail;
    logic                   all_done;
    logic                   at_limit;
    logic                   cand_vld;
    logic [IDX_W-1:0]       cand_idx;
    logic [DATA_W-1:0]      cand_code;

    // First completion store per hart; later stores from a finished hart are
    // masked by hart_done.
    always_comb begin
        new_done = '0;
        new_fail = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (state == RUN && mem_we[i] &&
                mem_addr[i*ADDR_W +: ADDR_W] == TOHOST_ADDR && !hart_done[i]) begin
                new_done[i] = 1'b1;
                new_fail[i] = (mem_wdata[i*DATA_W +: DATA_W] != DATA_W'(1));
            end
        end
    end

    // Lowest-index new failure that outranks any failure already recorded.
    // A fail flag is kept separately because a failing value may itself be 0.
    always_comb begin
        cand_vld  = 1'b0;
        cand_idx  = '0;
        cand_code = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (!cand_vld && new_fail[i] && (!any_fail || IDX_W'(i) < fail_idx)) begin
                cand_vld  = 1'b1;
                cand_idx  = IDX_W'(i);
                cand_code = mem_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign all_done = &(hart_done | new_done);
    assign at_limit = (cycle_count == CNT_W'(MAX_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RESET;
            RESET:   if (rst_cnt == CNT_W'(RESET_CYCLES - 1)) state_nxt = RUN;
            RUN:     if (all_done || at_limit) state_nxt = DONE;
            DONE:    if (start) state_nxt = RESET;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        core_rst = 1'b1;
        running  = 1'b0;
        done     = 1'b0;
        case (state)
            RUN: begin
                core_rst = 1'b0;
                running  = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt     <= '0;
            cycle_count <= '0;
            hart_done   <= '0;
            exit_code   <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            any_fail    <= 1'b0;
            fail_idx    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rst_cnt     <= '0;
                        cycle_count <= '0;
                        hart_done   <= '0;
                        exit_code   <= '0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        any_fail    <= 1'b0;
                        fail_idx    <= '0;
                    end
                end
                RESET: rst_cnt <= rst_cnt + CNT_W'(1);
                RUN: begin
                    cycle_count <= cycle_count + CNT_W'(1);
                    hart_done   <= hart_done | new_done;
                    if (cand_vld) begin
                        any_fail  <= 1'b1;
                        fail_idx  <= cand_idx;
                        exit_code <= cand_code;
                    end
                    // Completion takes priority over a coincident timeout.
                    if (all_done) begin
                        pass    <= !(any_fail || cand_vld);
                        timeout <= 1'b0;
                    end else if (at_limit) begin
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults (1 hart, RESET_CYCLES=1, MAX_CYCLES=25)
    logic        rst_a = 1'b1, start_a = 1'b0;
    logic [0:0]  we_a = '0;
    logic [31:0] addr_a = '0, wdata_a = '0;
    logic        core_rst_a, running_a, done_a, pass_a, timeout_a;
    logic [0:0]  hart_done_a;
    logic [31:0] exit_code_a, cc_a;

    core_run_ctrl u_a (
        .clk(clk), .rst(rst_a), .start(start_a),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .core_rst(core_rst_a), .running(running_a), .done(done_a),
        .pass(pass_a), .timeout(timeout_a), .hart_done(hart_done_a),
        .exit_code(exit_code_a), .cycle_count(cc_a)
    );

    // Instance B: 2 harts, RESET_CYCLES=3
    logic        rst_b = 1'b1, start_b = 1'b0;
    logic [1:0]  we_b = '0;
    logic [63:0] addr_b = '0, wdata_b = '0;
    logic        core_rst_b, running_b, done_b, pass_b, timeout_b;
    logic [1:0]  hart_done_b;
    logic [31:0] exit_code_b, cc_b;

    core_run_ctrl #(.NUM_HARTS(2), .RESET_CYCLES(3)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .core_rst(core_rst_b), .running(running_b), .done(done_b),
        .pass(pass_b), .timeout(timeout_b), .hart_done(hart_done_b),
        .exit_code(exit_code_b), .cycle_count(cc_b)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start pulse on A; returns in RUN cycle 0.
    task automatic launch_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
    endtask

    // One-cycle store on A, issued in the current cycle.
    task automatic store_a(input logic [31:0] addr, input logic [31:0] data);
        we_a = 1'b1; addr_a = addr; wdata_a = data;
        step();
        we_a = 1'b0; addr_a = '0; wdata_a = '0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        step(); step();
        rst_a = 1'b0; rst_b = 1'b0;
        checks++; if (core_rst_a !== 1'b1) begin errors++; $display("FAIL reset_core_rst got=%0h exp=1", core_rst_a); end
        checks++; if ({running_a, done_a, pass_a, timeout_a} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {running_a, done_a, pass_a, timeout_a}); end
        checks++; if ({hart_done_a, exit_code_a, cc_a} !== 65'd0) begin errors++; $display("FAIL reset_results got=%0h exp=0", {hart_done_a, exit_code_a, cc_a}); end
        checks++; if ({core_rst_b, running_b, done_b, hart_done_b} !== 5'b10000) begin errors++; $display("FAIL reset_b got=%b exp=10000", {core_rst_b, running_b, done_b, hart_done_b}); end
    endtask

    task automatic test_release_and_count();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++; if ({core_rst_a, running_a} !== 2'b10) begin errors++; $display("FAIL reset_state_hold got=%b exp=10", {core_rst_a, running_a}); end
        step();
        checks++; if ({core_rst_a, running_a, cc_a} !== {2'b01, 32'd0}) begin errors++; $display("FAIL run_entry got=%0h exp=%0h", {core_rst_a, running_a, cc_a}, {2'b01, 32'd0}); end
        step();
        checks++; if (cc_a !== 32'd1) begin errors++; $display("FAIL count_1 got=%0d exp=1", cc_a); end
        step();
        checks++; if (cc_a !== 32'd2) begin errors++; $display("FAIL count_2 got=%0d exp=2", cc_a); end
    endtask

    task automatic test_pass();
        repeat (7) step();    // now at RUN cycle 9
        checks++; if (cc_a !== 32'd9) begin errors++; $display("FAIL pass_pre_count got=%0d exp=9", cc_a); end
        store_a(32'h0000_1000, 32'd1);
        checks++; if ({done_a, pass_a, timeout_a, core_rst_a, running_a} !== 5'b11010) begin errors++; $display("FAIL pass_flags got=%b exp=11010", {done_a, pass_a, timeout_a, core_rst_a, running_a}); end
        checks++; if (cc_a !== 32'd10) begin errors++; $display("FAIL pass_count got=%0d exp=10", cc_a); end
        checks++; if ({hart_done_a, exit_code_a} !== {1'b1, 32'd0}) begin errors++; $display("FAIL pass_results got=%0h exp=%0h", {hart_done_a, exit_code_a}, {1'b1, 32'd0}); end
        step();
        checks++; if ({done_a, pass_a, cc_a} !== {2'b11, 32'd10}) begin errors++; $display("FAIL pass_hold got=%0h exp=%0h", {done_a, pass_a, cc_a}, {2'b11, 32'd10}); end
    endtask

    task automatic test_fail_code();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++; if ({done_a, pass_a, hart_done_a, cc_a} !== 35'd0) begin errors++; $display("FAIL relaunch_clear got=%0h exp=0", {done_a, pass_a, hart_done_a, cc_a}); end
        step();
        repeat (3) step();
        store_a(32'h0000_1000, 32'h0000_002B);
        checks++; if ({done_a, pass_a, exit_code_a, cc_a} !== {2'b10, 32'h2B, 32'd4}) begin errors++; $display("FAIL fail_result got=%0h exp=%0h", {done_a, pass_a, exit_code_a, cc_a}, {2'b10, 32'h2B, 32'd4}); end
        step();
        store_a(32'h0000_1000, 32'd1);   // after completion: must be ignored
        checks++; if ({done_a, pass_a, exit_code_a, cc_a} !== {2'b10, 32'h2B, 32'd4}) begin errors++; $display("FAIL fail_late_store got=%0h exp=%0h", {done_a, pass_a, exit_code_a, cc_a}, {2'b10, 32'h2B, 32'd4}); end
    endtask

    task automatic test_timeout();
        launch_a();
        repeat (24) step();
        checks++; if ({done_a, running_a, cc_a} !== {2'b01, 32'd24}) begin errors++; $display("FAIL timeout_pre got=%0h exp=%0h", {done_a, running_a, cc_a}, {2'b01, 32'd24}); end
        step();
        checks++; if ({done_a, timeout_a, pass_a, core_rst_a} !== 4'b1101) begin errors++; $display("FAIL timeout_flags got=%b exp=1101", {done_a, timeout_a, pass_a, core_rst_a}); end
        checks++; if ({exit_code_a, cc_a} !== {32'd0, 32'd25}) begin errors++; $display("FAIL timeout_count got=%0h exp=%0h", {exit_code_a, cc_a}, {32'd0, 32'd25}); end
        // completion on the last budget cycle wins over timeout
        launch_a();
        repeat (24) step();
        store_a(32'h0000_1000, 32'd1);
        checks++; if ({done_a, pass_a, timeout_a, cc_a} !== {3'b110, 32'd25}) begin errors++; $display("FAIL edge_complete got=%0h exp=%0h", {done_a, pass_a, timeout_a, cc_a}, {3'b110, 32'd25}); end
    endtask

    task automatic test_rst_mid_run();
        launch_a();
        repeat (5) step();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        checks++; if ({core_rst_a, running_a, done_a, pass_a, timeout_a} !== 5'b10000) begin errors++; $display("FAIL midrst_flags got=%b exp=10000", {core_rst_a, running_a, done_a, pass_a, timeout_a}); end
        checks++; if ({hart_done_a, exit_code_a, cc_a} !== 65'd0) begin errors++; $display("FAIL midrst_results got=%0h exp=0", {hart_done_a, exit_code_a, cc_a}); end
        store_a(32'h0000_1000, 32'd5);   // store in IDLE: ignored
        step();
        checks++; if ({core_rst_a, running_a, hart_done_a, exit_code_a} !== {3'b100, 32'd0}) begin errors++; $display("FAIL idle_store got=%0h exp=%0h", {core_rst_a, running_a, hart_done_a, exit_code_a}, {3'b100, 32'd0}); end
        launch_a();
        checks++; if ({core_rst_a, running_a, cc_a} !== {2'b01, 32'd0}) begin errors++; $display("FAIL relaunch_run got=%0h exp=%0h", {core_rst_a, running_a, cc_a}, {2'b01, 32'd0}); end
        step(); step();
        checks++; if (cc_a !== 32'd2) begin errors++; $display("FAIL relaunch_count got=%0d exp=2", cc_a); end
    endtask

    task automatic test_multi_hart();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({core_rst_b, running_b} !== 2'b10) begin errors++; $display("FAIL mh_reset_cyc%0d got=%b exp=10", k, {core_rst_b, running_b}); end
            step();
        end
        checks++; if ({core_rst_b, running_b, cc_b} !== {2'b01, 32'd0}) begin errors++; $display("FAIL mh_run_entry got=%0h exp=%0h", {core_rst_b, running_b, cc_b}, {2'b01, 32'd0}); end
        step(); step();                  // cycle 2: hart0 stores to non-tohost address
        we_b = 2'b01; addr_b = {32'd0, 32'h0000_1004}; wdata_b = {32'd0, 32'd1};
        step();
        we_b = '0;
        step();                          // cycle 4: hart1 stores 1
        we_b = 2'b10; addr_b = {32'h0000_1000, 32'd0}; wdata_b = {32'd1, 32'd0};
        step();
        we_b = '0;
        checks++; if ({hart_done_b, done_b, cc_b} !== {3'b100, 32'd5}) begin errors++; $display("FAIL mh_hart1 got=%0h exp=%0h", {hart_done_b, done_b, cc_b}, {3'b100, 32'd5}); end
        step();                          // cycle 6: hart0 stores 7
        we_b = 2'b01; addr_b = {32'd0, 32'h0000_1000}; wdata_b = {32'd0, 32'd7};
        step();
        we_b = '0;
        checks++; if ({hart_done_b, done_b, pass_b, timeout_b} !== 5'b11100) begin errors++; $display("FAIL mh_done got=%b exp=11100", {hart_done_b, done_b, pass_b, timeout_b}); end
        checks++; if ({exit_code_b, cc_b} !== {32'd7, 32'd7}) begin errors++; $display("FAIL mh_code got=%0h exp=%0h", {exit_code_b, cc_b}, {32'd7, 32'd7}); end
    endtask

    task automatic test_back_to_back();
        // both harts fail on the same edge: lowest index reports
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        repeat (3) step();
        we_b = 2'b11; addr_b = {32'h0000_1000, 32'h0000_1000}; wdata_b = {32'd5, 32'd9};
        step();
        we_b = '0;
        checks++; if ({hart_done_b, done_b, pass_b} !== 4'b1110) begin errors++; $display("FAIL same_edge_flags got=%b exp=1110", {hart_done_b, done_b, pass_b}); end
        checks++; if ({exit_code_b, cc_b} !== {32'd9, 32'd1}) begin errors++; $display("FAIL same_edge_code got=%0h exp=%0h", {exit_code_b, cc_b}, {32'd9, 32'd1}); end
    endtask

    initial begin
        #1;
        test_reset();
        test_release_and_count();
        test_pass();
        test_fail_code();
        test_timeout();
        test_rst_mid_run();
        test_multi_hart();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Synthesizable run controller that replaces ad-hoc testbench reset and timeout sequencing for single-cycle and multi-hart RISC-V tops. It holds the core(s) in reset for a programmable number of cycles, then releases them and counts run cycles. It detects completion through per-hart stores to a "tohost" address and reports pass, fail or timeout. It sits between the top-level clk/rst and the core_rst input of one or more cores, and snoops each hart's data-memory write port.

Parameters:
NUM_HARTS, 1, number of snooped hart write ports
ADDR_W, 32, store address width
DATA_W, 32, store data width
CNT_W, 32, cycle counter width
RESET_CYCLES, 1, cycles core_rst is held in RESET state (>=1)
MAX_CYCLES, 25, run-cycle budget before timeout (>=1, < 2^CNT_W)
TOHOST_ADDR, 32'h0000_1000, completion store address

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  launch/relaunch pulse
mem_we  in  NUM_HARTS  per-hart store enable
mem_addr  in  NUM_HARTS*ADDR_W  per-hart store address, hart i at [i*ADDR_W +: ADDR_W]
mem_wdata  in  NUM_HARTS*DATA_W  per-hart store data, same packing
core_rst  out  1  reset to core(s), active-high
running  out  1  high in RUN state
done  out  1  high in DONE state
pass  out  1  valid when done
timeout  out  1  valid when done
hart_done  out  NUM_HARTS  per-hart completion seen
exit_code  out  DATA_W  failing code of lowest-index failing hart, else 0
cycle_count  out  CNT_W  run cycles elapsed

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst. All state is registered.
- Reset values: state IDLE, core_rst=1, running=0, done=0, pass=0, timeout=0, hart_done=0, exit_code=0, cycle_count=0.
- FSM states are IDLE, RESET, RUN, DONE.
- IDLE: core_rst=1. When start=1, go to RESET, load rst_cnt=0 and clear hart_done, exit_code, pass, timeout and cycle_count.
- RESET: core_rst=1. rst_cnt increments each cycle. When rst_cnt==RESET_CYCLES-1, go to RUN. core_rst is therefore high for exactly RESET_CYCLES cycles in RESET.
- RUN: core_rst=0 and running=1. cycle_count increments by 1 on every RUN edge.
- Completion store for hart i: mem_we[i]=1 and mem_addr_i==TOHOST_ADDR, sampled in RUN only.
  - The first completion store sets hart_done[i].
  - Any later stores from that hart are ignored.
  - wdata==1 means the hart passed. Any other value means it failed.
- Exit DONE (completion): taken on the edge where all hart_done bits, including those set on the same edge, are 1. done rises the cycle after the final store. cycle_count then equals the RUN-cycle index of that store plus 1.
- Exit DONE (timeout): taken on the edge where cycle_count==MAX_CYCLES-1 without full completion. cycle_count becomes MAX_CYCLES and timeout=1.
- Simultaneous completion and timeout edge: completion wins, so timeout=0.
- pass=1 only if all harts stored 1 and timeout=0.
- exit_code = wdata of the lowest-index hart whose completion value was not 1. It is 0 on timeout unless a failing hart already reported.
- DONE: core_rst=1 (cores frozen), done=1. Outputs are held. start=1 goes to RESET with results cleared.
- start is ignored in RESET and RUN.
- Stores in IDLE, RESET and DONE are ignored.
- rst asserted in any state, including mid-RUN, returns to IDLE with reset values on the next edge.
- Multiple harts completing on the same edge are all recorded on that edge.

Test Plan:
- Defaults, rst high for 2 cycles, then start pulse → core_rst stays high 1 cycle after start, then low; running=1; cycle_count increments 0,1,2…
- NUM_HARTS=1, store 1 to 0x1000 at RUN cycle 9 → next cycle done=1, pass=1, timeout=0, cycle_count=10, exit_code=0, core_rst=1.
- Store 0x0000_002B to 0x1000 at cycle 3, then store 1 at cycle 5 → done at cycle 4, pass=0, exit_code=0x2B, the second store ignored.
- No completion store, MAX_CYCLES=25 → done=1, timeout=1, pass=0, cycle_count=25. Also: a completion store exactly at cycle 24 → pass=1, timeout=0.
- NUM_HARTS=2, RESET_CYCLES=3: hart1 stores 1 at cycle 4, hart0 stores 7 at cycle 6, plus a hart0 store to 0x1004 at cycle 2 → core_rst high 3 cycles; hart_done=2'b10 after cycle 4; done after cycle 6; pass=0, exit_code=7.
- rst pulse at RUN cycle 5, then start again → IDLE with all outputs at reset values; the relaunch repeats the full RESET/RUN sequence with cycle_count restarting at 0.
